// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: definitions shared by the memory bus arbiter and its grant selector.
//   arb_state_t       : arbiter FSM states (IDLE, ACCESS, ACK)
//   OWN_CPU / OWN_LDR : owner/winner encodings for requester 0 (CPU) and requester 1 (loader)
//   RDWR_RD / RDWR_WR : encodings for the rdwr direction bit
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  localparam logic RDWR_RD = 1'b0;
  localparam logic RDWR_WR = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selection between the CPU (m0) and the
// loader/debug port (m1).
//   m0_req, m1_req : current request lines
//   owner          : current or last granted requester
//   any_req        : at least one request is pending
//   winner         : requester to grant when the arbiter is idle
// Build option: define MEM_ARB_RR_EN for round-robin on ties (the requester
// that is not the current owner wins); otherwise m0 has fixed priority.
// A lone requester is always granted directly in both modes.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic m0_req,
  input  logic m1_req,
  input  logic owner,
  output logic any_req,
  output logic winner
);

  always_comb begin
    any_req = m0_req | m1_req;
    winner  = OWN_CPU;
`ifdef MEM_ARB_RR_EN
    if (m0_req && m1_req) begin
      winner = ~owner;
    end else if (m1_req) begin
      winner = OWN_LDR;
    end
`else
    if (!m0_req && m1_req) begin
      winner = OWN_LDR;
    end
`endif
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one AW x DW memory port between the CPU (m0) and the
// program loader/debug port (m1).
//   clkin, rst            : clock; synchronous active-high reset
//   m0_* / m1_*           : requester ports (req, rdwr, addr, wdata in; ack, rdata out)
//   mem_en, mem_rdwr,
//   mem_addr, mem_wdata   : memory macro controls, stable for the whole access
//   mem_rdata             : memory read data, sampled on the last enabled cycle
//   busy                  : FSM is not IDLE
//   owner                 : current or last granted requester (resets to loader)
// An access runs IDLE -> ACCESS (RD_LAT cycles with mem_en high) -> ACK (one
// cycle, owner's ack high) -> IDLE. Build option MEM_ARB_RR_EN selects
// round-robin arbitration in mem_arb_pick.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW     = 12,
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_rdwr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_rdwr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_rdwr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  if ((RD_LAT < 1) || (RD_LAT > 15)) begin : g_rd_lat_check
    $error("mem_bus_arbiter: RD_LAT must be within 1..15");
  end

  // The wait counter counts down from RD_LAT-1; reaching zero ends ACCESS.
  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

  arb_state_t state;
  arb_state_t state_next;
  logic [3:0] cnt;
  logic       any_req;
  logic       winner;

  mem_arb_pick u_pick (
    .m0_req  (m0_req),
    .m1_req  (m1_req),
    .owner   (owner),
    .any_req (any_req),
    .winner  (winner)
  );

  // State register
  always_ff @(posedge clkin) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  if (cnt == '0) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: enable, busy and acks follow directly from the state, so
  // mem_en is high for exactly the RD_LAT ACCESS cycles.
  always_comb begin
    mem_en = 1'b0;
    busy   = 1'b0;
    m0_ack = 1'b0;
    m1_ack = 1'b0;
    case (state)
      ACCESS: begin
        mem_en = 1'b1;
        busy   = 1'b1;
      end
      ACK: begin
        busy   = 1'b1;
        m0_ack = (owner == OWN_CPU);
        m1_ack = (owner == OWN_LDR);
      end
      default: ;
    endcase
  end

  // Grant latch, wait counter and read-data capture
  always_ff @(posedge clkin) begin
    if (rst) begin
      owner     <= OWN_LDR;
      mem_rdwr  <= RDWR_RD;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= winner;
            mem_rdwr  <= (winner == OWN_LDR) ? m1_rdwr  : m0_rdwr;
            mem_addr  <= (winner == OWN_LDR) ? m1_addr  : m0_addr;
            mem_wdata <= (winner == OWN_LDR) ? m1_wdata : m0_wdata;
            cnt       <= LAT_LOAD;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else if (mem_rdwr == RDWR_RD) begin
            if (owner == OWN_LDR) begin
              m1_rdata <= mem_rdata;
            end else begin
              m0_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: self-checking bench for mem_bus_arbiter. Three instances
// (RD_LAT = 1, 3, 4) each get their own requesters and memory array. A
// transaction-level reference model tracks grants, ack timing and expected
// read data every cycle; directed table vectors and sequences add fixed
// expectations for latency, contention, reset and re-request cases.
module tb_mem_bus_arbiter;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [NI][2];
  logic        rdwr  [NI][2];
  logic [11:0] addr  [NI][2];
  logic [15:0] wdata [NI][2];
  logic        ack   [NI][2];
  logic [15:0] rdata [NI][2];
  logic        mem_en    [NI];
  logic        mem_rdwr  [NI];
  logic [11:0] mem_addr  [NI];
  logic [15:0] mem_wdata [NI];
  logic [15:0] mem_rdata [NI];
  logic        busy      [NI];
  logic        owner     [NI];
  logic [15:0] tbmem     [NI][4096];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_bus_arbiter #(
      .AW     (12),
      .DW     (16),
      .RD_LAT (g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .clkin     (clk),
      .rst       (rst),
      .m0_req    (req[g][0]),
      .m0_rdwr   (rdwr[g][0]),
      .m0_addr   (addr[g][0]),
      .m0_wdata  (wdata[g][0]),
      .m0_ack    (ack[g][0]),
      .m0_rdata  (rdata[g][0]),
      .m1_req    (req[g][1]),
      .m1_rdwr   (rdwr[g][1]),
      .m1_addr   (addr[g][1]),
      .m1_wdata  (wdata[g][1]),
      .m1_ack    (ack[g][1]),
      .m1_rdata  (rdata[g][1]),
      .mem_en    (mem_en[g]),
      .mem_rdwr  (mem_rdwr[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g]),
      .owner     (owner[g])
    );
    assign mem_rdata[g] = tbmem[g][mem_addr[g]];
  end

  int checks = 0;
  int errors = 0;
  int ecount = 0;

  // Reference model: one outstanding transaction per instance, described by
  // its grant edge; everything else follows from the latency arithmetic.
  bit          m_act  [NI];
  int          m_gk   [NI];
  logic        m_own  [NI];
  logic        m_rw   [NI];
  logic [11:0] m_addr [NI];
  logic [15:0] m_wd   [NI];
  logic [15:0] m_rd   [NI][2];
  logic [15:0] golden [NI][4096];

  typedef struct {
    int          inst;
    bit          who;
    bit          rw;
    logic [11:0] a;
    logic [15:0] wd;
    bit          pre;
    logic [15:0] memval;
    int          exp_lat;
    int          exp_en;
    logic [15:0] exp_own;
    logic [15:0] exp_oth;
  } vec_t;

  vec_t tbl[6];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %h expected %h (edge %0d)", nm, i, got, exp, ecount);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      int   lat;
      logic w;
      lat = lat_of(i);
      if (rst) begin
        m_act[i]   = 1'b0;
        m_own[i]   = 1'b1;
        m_rw[i]    = 1'b0;
        m_addr[i]  = '0;
        m_wd[i]    = '0;
        m_rd[i][0] = '0;
        m_rd[i][1] = '0;
      end else begin
        if (m_act[i] && ecount == m_gk[i] + lat && !m_rw[i])
          m_rd[i][m_own[i]] = golden[i][m_addr[i]];
        if ((!m_act[i] || ecount >= m_gk[i] + lat + 2) && (req[i][0] || req[i][1])) begin
          if (req[i][0] && req[i][1]) begin
`ifdef MEM_ARB_RR_EN
            w = ~m_own[i];
`else
            w = 1'b0;
`endif
          end else begin
            w = req[i][1];
          end
          m_act[i]  = 1'b1;
          m_gk[i]   = ecount;
          m_own[i]  = w;
          m_rw[i]   = rdwr[i][w];
          m_addr[i] = addr[i][w];
          m_wd[i]   = wdata[i][w];
          if (m_rw[i]) golden[i][m_addr[i]] = m_wd[i];
        end
      end
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < NI; i++) begin
      int lat;
      int ph;
      bit in_acc;
      bit in_ack;
      lat    = lat_of(i);
      ph     = ecount - m_gk[i];
      in_acc = m_act[i] && ph < lat;
      in_ack = m_act[i] && ph == lat;
      chk("busy",      i, 32'(busy[i]),      32'(in_acc || in_ack));
      chk("mem_en",    i, 32'(mem_en[i]),    32'(in_acc));
      chk("m0_ack",    i, 32'(ack[i][0]),    32'(in_ack && m_own[i] == 1'b0));
      chk("m1_ack",    i, 32'(ack[i][1]),    32'(in_ack && m_own[i] == 1'b1));
      chk("owner",     i, 32'(owner[i]),     32'(m_own[i]));
      chk("m0_rdata",  i, 32'(rdata[i][0]),  32'(m_rd[i][0]));
      chk("m1_rdata",  i, 32'(rdata[i][1]),  32'(m_rd[i][1]));
      chk("mem_addr",  i, 32'(mem_addr[i]),  32'(m_addr[i]));
      chk("mem_rdwr",  i, 32'(mem_rdwr[i]),  32'(m_rw[i]));
      chk("mem_wdata", i, 32'(mem_wdata[i]), 32'(m_wd[i]));
      if (mem_en[i] === 1'b1 && mem_rdwr[i] === 1'b1)
        tbmem[i][mem_addr[i]] = mem_wdata[i];
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    ecount++;
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic new_txn(input int i, input int r);
    rdwr[i][r]  = 1'($urandom_range(1));
    addr[i][r]  = 12'($urandom_range(15));
    wdata[i][r] = 16'($urandom);
  endtask

  task automatic run_vec(input vec_t v);
    int          n;
    int          en_cnt;
    int          oth;
    bit          seen;
    logic [11:0] c_addr;
    logic        c_rw;
    logic [15:0] c_wd;
    if (v.pre) begin
      tbmem[v.inst][v.a]  = v.memval;
      golden[v.inst][v.a] = v.memval;
    end
    rdwr[v.inst][v.who]  = v.rw;
    addr[v.inst][v.who]  = v.a;
    wdata[v.inst][v.who] = v.wd;
    req[v.inst][v.who]   = 1'b1;
    n = 0; en_cnt = 0; oth = 0; seen = 1'b0;
    c_addr = '0; c_rw = 1'b0; c_wd = '0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (mem_en[v.inst]) begin
        en_cnt++;
        if (en_cnt == 1) begin
          c_addr = mem_addr[v.inst];
          c_rw   = mem_rdwr[v.inst];
          c_wd   = mem_wdata[v.inst];
        end
      end
      if (ack[v.inst][!v.who]) oth++;
      if (ack[v.inst][v.who]) seen = 1'b1;
    end
    req[v.inst][v.who] = 1'b0;
    chk("vec_latency",   v.inst, n,      v.exp_lat);
    chk("vec_en_cycles", v.inst, en_cnt, v.exp_en);
    chk("vec_mem_addr",  v.inst, 32'(c_addr), 32'(v.a));
    chk("vec_mem_rdwr",  v.inst, 32'(c_rw),   32'(v.rw));
    if (v.rw) chk("vec_mem_wdata", v.inst, 32'(c_wd), 32'(v.wd));
    chk("vec_other_ack", v.inst, oth, 0);
    chk("vec_own_rdata", v.inst, 32'(rdata[v.inst][v.who]),  32'(v.exp_own));
    chk("vec_oth_rdata", v.inst, 32'(rdata[v.inst][!v.who]), 32'(v.exp_oth));
    tick();
  endtask

  initial begin
    int n;
    int t0;
    int t1;
    int first;
    int k;
    int acks;
    int ens;
    int seq[4];
    int exp_seq[4];

    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      for (int r = 0; r < 2; r++) begin
        req[i][r] = 1'b0; rdwr[i][r] = 1'b0; addr[i][r] = '0; wdata[i][r] = '0;
      end
      for (int a = 0; a < 4096; a++) begin
        tbmem[i][a]  = 16'($urandom);
        golden[i][a] = tbmem[i][a];
      end
    end

    tbl[0] = '{0, 1'b0, 1'b0, 12'h010, 16'h0000, 1'b1, 16'hBEEF, 2, 1, 16'hBEEF, 16'h0000};
    tbl[1] = '{1, 1'b1, 1'b1, 12'hFFF, 16'h1234, 1'b0, 16'h0000, 4, 3, 16'h0000, 16'h0000};
    tbl[2] = '{1, 1'b1, 1'b0, 12'hFFF, 16'h0000, 1'b0, 16'h0000, 4, 3, 16'h1234, 16'h0000};
    tbl[3] = '{2, 1'b0, 1'b1, 12'h000, 16'hABCD, 1'b0, 16'h0000, 5, 4, 16'h0000, 16'h0000};
    tbl[4] = '{2, 1'b1, 1'b0, 12'h000, 16'h0000, 1'b0, 16'h0000, 5, 4, 16'hABCD, 16'h0000};
    tbl[5] = '{0, 1'b1, 1'b0, 12'h7FF, 16'h0000, 1'b1, 16'h5A5A, 2, 1, 16'h5A5A, 16'hBEEF};

    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk("rst_owner",    i, 32'(owner[i]),    1);
      chk("rst_busy",     i, 32'(busy[i]),     0);
      chk("rst_mem_en",   i, 32'(mem_en[i]),   0);
      chk("rst_mem_addr", i, 32'(mem_addr[i]), 0);
      chk("rst_m0_rdata", i, 32'(rdata[i][0]), 0);
    end
    tick();

    for (int v = 0; v < 6; v++) run_vec(tbl[v]);

    // Reset during ACCESS on the RD_LAT=4 instance
    rdwr[2][0] = 1'b0; addr[2][0] = 12'h000; req[2][0] = 1'b1;
    tick();
    tick();
    chk("rst_mid_pre_en", 2, 32'(mem_en[2]), 1);
    rst = 1'b1; req[2][0] = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_mid_en",     2, 32'(mem_en[2]),   0);
    chk("rst_mid_busy",   2, 32'(busy[2]),     0);
    chk("rst_mid_rdata1", 2, 32'(rdata[2][1]), 0);
    chk("rst_mid_owner",  2, 32'(owner[2]),    1);
    acks = 0;
    repeat (6) begin
      tick();
      if (ack[2][0] || ack[2][1]) acks++;
    end
    chk("rst_mid_no_ack", 2, acks, 0);
    req[2][0] = 1'b1;
    n = 0;
    while (!ack[2][0] && n < 40) begin
      tick();
      n++;
    end
    req[2][0] = 1'b0;
    chk("rst_fresh_latency", 2, n, 5);
    chk("rst_fresh_rdata",   2, 32'(rdata[2][0]), 32'h0000ABCD);
    tick();

    // Stale request: req held one cycle into IDLE, then dropped mid-ACCESS
    rdwr[0][0] = 1'b0; addr[0][0] = 12'h010; req[0][0] = 1'b1;
    acks = 0; ens = 0; n = 0;
    while (acks == 0 && n < 40) begin
      tick();
      n++;
      if (mem_en[0]) ens++;
      if (ack[0][0]) acks++;
    end
    tick();
    if (mem_en[0]) ens++;
    tick();
    if (mem_en[0]) ens++;
    req[0][0] = 1'b0;
    repeat (8) begin
      tick();
      if (mem_en[0]) ens++;
      if (ack[0][0]) acks++;
    end
    chk("stale_acks",    0, acks, 2);
    chk("stale_en",      0, ens,  2);
    chk("stale_rdata",   0, 32'(rdata[0][0]), 32'h0000BEEF);

    // Contention on the RD_LAT=3 instance, each requester drops after its ack
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rdwr[1][0] = 1'b0; addr[1][0] = 12'h001; req[1][0] = 1'b1;
    rdwr[1][1] = 1'b0; addr[1][1] = 12'h002; req[1][1] = 1'b1;
    t0 = -1; t1 = -1; first = -1; n = 0;
    while ((t0 < 0 || t1 < 0) && n < 60) begin
      tick();
      n++;
      if (ack[1][0] && t0 < 0) begin t0 = n; req[1][0] = 1'b0; if (first < 0) first = 0; end
      if (ack[1][1] && t1 < 0) begin t1 = n; req[1][1] = 1'b0; if (first < 0) first = 1; end
    end
    chk("cont_both_served", 1, 32'(t0 >= 0 && t1 >= 0), 1);
    chk("cont_first_owner", 1, first, 0);
    chk("cont_m0_latency",  1, t0, 4);
    chk("cont_gap",         1, t1 - t0, 5);

    // Both requesters re-request continuously for four grants
`ifdef MEM_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    seq = '{-1, -1, -1, -1};
    req[1][0] = 1'b1; req[1][1] = 1'b1;
    k = 0; n = 0;
    while (k < 4 && n < 80) begin
      tick();
      n++;
      if (ack[1][0]) begin seq[k] = 0; k++; end
      else if (ack[1][1]) begin seq[k] = 1; k++; end
    end
    req[1][0] = 1'b0; req[1][1] = 1'b0;
    chk("cont_grants", 1, k, 4);
    for (int j = 0; j < 4; j++) chk("cont_order", 1, seq[j], exp_seq[j]);
    tick();
    tick();

    // Randomized protocol-compliant traffic on all instances
    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        for (int r = 0; r < 2; r++) begin
          if (req[i][r]) begin
            if (ack[i][r]) begin
              if ($urandom_range(2) == 0) new_txn(i, r);
              else req[i][r] = 1'b0;
            end else if (m_act[i] && m_own[i] == 1'(r) && (ecount - m_gk[i]) < lat_of(i)
                         && $urandom_range(15) == 0) begin
              req[i][r] = 1'b0;
            end
          end else if ($urandom_range(3) == 0) begin
            new_txn(i, r);
            req[i][r] = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      req[i][0] = 1'b0;
      req[i][1] = 1'b0;
    end
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 4K x 16 program/data memory port between two requesters: requester 0 is the CPU core, requester 1 is the external program loader/debug port.
- Performs grant selection, sequences each access over a configurable memory latency, and returns read data with a one-cycle ack pulse.
- Sits between the requesters and the memory macro's en/rdwr/addr/data pins.

Parameters:
- AW, 12, address width (4K words)
- DW, 16, data width
- RD_LAT, 1, cycles mem_en is held before mem_rdata is sampled; legal range 1..15

Ports:
- clkin  input  1  system clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- m0_req  input  1  CPU access request; held until m0_ack
- m0_rdwr  input  1  CPU direction: 1 = write, 0 = read
- m0_addr  input  AW  CPU word address
- m0_wdata  input  DW  CPU write data
- m0_ack  output  1  one-cycle completion pulse to CPU
- m0_rdata  output  DW  CPU read data, valid while m0_ack=1 and held afterwards
- m1_req, m1_rdwr, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0_*, loader side
- mem_en  output  1  memory enable
- mem_rdwr  output  1  memory direction, 1 = write
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data
- busy  output  1  high whenever state is not IDLE
- owner  output  1  index of the current or last granted requester

Behaviour:
- Reset is synchronous and active-high on clkin/rst. It applies at any time, including mid-access, and the in-flight access is abandoned with no ack.
  - state=IDLE, mem_en=0, mem_rdwr=0, mem_addr=0, mem_wdata=0
  - m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, busy=0
  - owner=1, wait counter=0
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - If any req is high, pick a winner (see arbitration) and go to ACCESS. At the same edge, latch owner, mem_rdwr, mem_addr and mem_wdata from the winner, set mem_en=1, and load counter=RD_LAT-1.
  - With no requests, stay in IDLE.
- ACCESS:
  - mem_en=1 and all mem_* outputs are held stable.
  - If counter≠0, decrement it.
  - If counter=0, go to ACK at that edge and clear mem_en. For a read, capture mem_rdata into the owner's rdata register; the other requester's rdata is unchanged. For a write, rdata is unchanged.
  - mem_en is therefore high for exactly RD_LAT cycles.
- ACK:
  - The owner's ack=1 for exactly one cycle, decoded from state==ACK and owner; the non-owner's ack stays 0.
  - Always goes to IDLE on the next edge.
- Latency: req sampled at edge k gives ack high in cycle k+RD_LAT+1. Throughput is one access per RD_LAT+2 cycles.
- Requester protocol:
  - req, rdwr, addr and wdata must be stable from assertion until ack.
  - The requester drops req on the edge that ends the ack cycle. If req is still high in the following IDLE cycle, it is treated as a new request.
- req dropped during ACCESS: the access completes anyway and ack still pulses; the arbiter does not cancel.
- Arbitration (default): fixed priority, m0 wins over m1 when both request in IDLE. m1 can be starved by continuous m0 traffic; this is accepted.
- owner holds its value in IDLE after a transaction.
- Addresses are passed through unmodified, with no wrap logic.
- RD_LAT outside 1..15 is a compile-time error via an elaboration check.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. On simultaneous requests, grant the requester not equal to owner. owner resets to 1, so m0 wins the first tie.
- MEM_ARB_RR_EN undefined: fixed priority m0 > m1 as above.
- A single requester is granted immediately in both modes.

Decomposition:
- Shared package mem_arb_pkg:
  - state typedef: IDLE=2'd0, ACCESS=2'd1, ACK=2'd2
  - constants OWN_CPU=1'b0, OWN_LDR=1'b1
  - constants RDWR_RD=1'b0, RDWR_WR=1'b1
- One natural sub-module, mem_arb_pick: combinational grant select from (m0_req, m1_req, owner), containing the MEM_ARB_RR_EN variant.
- The FSM, counter and data path stay in mem_bus_arbiter.

Test Plan:
- Single read (RD_LAT=1): m0 reads addr 12'h010 while mem returns 16'hBEEF. Expect mem_en high for 1 cycle with mem_addr=12'h010 and mem_rdwr=0; m0_ack in cycle k+2 with m0_rdata=16'hBEEF; m1_ack stays 0.
- Single write (RD_LAT=3): m1 writes 16'h1234 to 12'hFFF. Expect mem_en high for 3 cycles with mem_rdwr=1 and mem_wdata=16'h1234; m1_ack in cycle k+4; m1_rdata unchanged.
- Contention, macro off: m0 and m1 both assert in the same cycle. Expect m0 served first and m1 served immediately after; m1_ack occurs RD_LAT+2 cycles after m0_ack.
- Contention, MEM_ARB_RR_EN on: both requesters re-request continuously for 4 transactions. Expect grants in order m0, m1, m0, m1.
- Reset mid-access (RD_LAT=4): assert rst for 1 cycle during ACCESS. Expect the next cycle to show mem_en=0, busy=0, no ack, and rdata=0; a fresh m0 read afterwards completes normally.
- Stale req: m0 keeps req high one cycle past ack. Expect a second access to start, proving the re-request rule; dropping req mid-ACCESS still produces exactly one ack.
